// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register file write port between NUM_REQ writeback sources.
// Optional statistics counters are enabled by defining REGFILE_WR_ARB_STATS_EN.
module regfile_wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 32,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  i_req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_wr_stall,
    output logic [ADDR_BITS-1:0]          o_wr_addr,
    output logic                          o_wr_enable,
    output logic [DATA_BITS-1:0]          o_wr_data,
    output logic [IDX_W-1:0]              o_grant_idx
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    output logic [15:0]                   o_conflict_count,
    output logic [15:0]                   o_stall_count
`endif
);

    logic [IDX_W-1:0]     r_rr_ptr;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic [DATA_BITS-1:0] r_wr_data;
    logic                 r_wr_enable;
    logic [IDX_W-1:0]     r_grant_idx;

    logic                 w_found;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]   w_ready;

    // Search starts at rr_ptr and wraps; the first valid requester wins unless stalled or in reset.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_ready   = '0;
        if (!i_reset && !i_wr_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_found && i_req_valid[w_idx]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = w_idx;
                end
            end
        end
        if (w_found) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_next_ptr = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr    <= '0;
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_grant_idx <= '0;
        end else begin
            r_wr_enable <= w_found;
            if (w_found) begin
                r_rr_ptr    <= w_next_ptr;
                r_wr_addr   <= i_req_addr[w_gnt_idx*ADDR_BITS +: ADDR_BITS];
                r_wr_data   <= i_req_data[w_gnt_idx*DATA_BITS +: DATA_BITS];
                r_grant_idx <= w_gnt_idx;
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_wr_enable = r_wr_enable;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_grant_idx = r_grant_idx;

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0] r_conflict_count;
    logic [15:0] r_stall_count;
    logic        w_multi_valid;
    int          w_valid_cnt;

    always_comb begin
        w_valid_cnt = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_valid_cnt = w_valid_cnt + int'(i_req_valid[k]);
        end
        w_multi_valid = (w_valid_cnt >= 2);
    end

    // Both counters saturate rather than wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_conflict_count <= '0;
            r_stall_count    <= '0;
        end else begin
            if (w_multi_valid && r_conflict_count != 16'hFFFF) begin
                r_conflict_count <= r_conflict_count + 16'd1;
            end
            if (i_wr_stall && (|i_req_valid) && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign o_conflict_count = r_conflict_count;
    assign o_stall_count    = r_stall_count;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (NUM_REQ=2, ADDR_BITS=4, DATA_BITS=8).
// Define REGFILE_WR_ARB_STATS_EN to also exercise the statistics counters.
module tb_regfile_wr_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int ADDR_BITS = 4;
    localparam int DATA_BITS = 8;

    logic                         clk;
    logic                         reset;
    logic [NUM_REQ-1:0]           reqValid;
    logic [NUM_REQ*ADDR_BITS-1:0] reqAddr;
    logic [NUM_REQ*DATA_BITS-1:0] reqData;
    logic [NUM_REQ-1:0]           reqReady;
    logic                         wrStall;
    logic [ADDR_BITS-1:0]         wrAddr;
    logic                         wrEnable;
    logic [DATA_BITS-1:0]         wrData;
    logic                         grantIdx;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0]                  conflictCount;
    logic [15:0]                  stallCount;
`endif

    int passCount;
    int checkCount;

    logic [DATA_BITS-1:0] regFile [16];

    regfile_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req_valid(reqValid),
        .i_req_addr (reqAddr),
        .i_req_data (reqData),
        .o_req_ready(reqReady),
        .i_wr_stall (wrStall),
        .o_wr_addr  (wrAddr),
        .o_wr_enable(wrEnable),
        .o_wr_data  (wrData),
        .o_grant_idx(grantIdx)
`ifdef REGFILE_WR_ARB_STATS_EN
        ,
        .o_conflict_count(conflictCount),
        .o_stall_count   (stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures whatever the write port strobes.
    always @(posedge clk) begin
        if (wrEnable) regFile[wrAddr] <= wrData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic [3:0] a1, input logic [7:0] d1, input logic stall);
        reqValid = valid;
        reqAddr  = {a1, a0};
        reqData  = {d1, d0};
        wrStall  = stall;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        applyStimulus(2'b11, 4'h1, 8'h11, 4'h2, 8'h22, 1'b0);
        stepCycle();
        stepCycle();

        // Reset state, with requests present to confirm ready is forced low
        checkOutput("rst_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_we", 32'(wrEnable), 32'h0);
        checkOutput("rst_addr", 32'(wrAddr), 32'h0);
        checkOutput("rst_data", 32'(wrData), 32'h0);
        checkOutput("rst_gidx", 32'(grantIdx), 32'h0);

        reset = 1'b0;
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
        stepCycle();
        checkOutput("idle_we", 32'(wrEnable), 32'h0);

        // Single request from requester 0
        applyStimulus(2'b01, 4'h3, 8'hA5, 4'h0, 8'h00, 1'b0);
        checkOutput("single_ready", 32'(reqReady), 32'h1);
        stepCycle();
        applyStimulus(2'b00, 4'h3, 8'hA5, 4'h0, 8'h00, 1'b0);
        checkOutput("single_we", 32'(wrEnable), 32'h1);
        checkOutput("single_addr", 32'(wrAddr), 32'h3);
        checkOutput("single_data", 32'(wrData), 32'hA5);
        checkOutput("single_gidx", 32'(grantIdx), 32'h0);
        stepCycle();
        checkOutput("single_we_off", 32'(wrEnable), 32'h0);
        checkOutput("single_addr_hold", 32'(wrAddr), 32'h3);

        // Continuous contention from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        applyStimulus(2'b11, 4'h1, 8'h11, 4'h2, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("cont_ready%0d", i), 32'(reqReady), (i % 2 == 0) ? 32'h1 : 32'h2);
            stepCycle();
            checkOutput($sformatf("cont_we%0d", i), 32'(wrEnable), 32'h1);
            checkOutput($sformatf("cont_addr%0d", i), 32'(wrAddr), (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("cont_data%0d", i), 32'(wrData), (i % 2 == 0) ? 32'h11 : 32'h22);
            checkOutput($sformatf("cont_gidx%0d", i), 32'(grantIdx), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
        stepCycle();
        checkOutput("cont_we_off", 32'(wrEnable), 32'h0);

        // Stall: registered write still completes, no new grants, pointer held
        applyStimulus(2'b01, 4'h7, 8'h77, 4'h8, 8'h88, 1'b0);
        checkOutput("stall_pre_ready", 32'(reqReady), 32'h1);
        stepCycle();
        applyStimulus(2'b11, 4'h7, 8'h77, 4'h8, 8'h88, 1'b1);
        checkOutput("stall0_ready", 32'(reqReady), 32'h0);
        checkOutput("stall0_we", 32'(wrEnable), 32'h1);
        checkOutput("stall0_addr", 32'(wrAddr), 32'h7);
        for (int i = 1; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("stall%0d_ready", i), 32'(reqReady), 32'h0);
            checkOutput($sformatf("stall%0d_we", i), 32'(wrEnable), 32'h0);
        end
        stepCycle();
        checkOutput("stall3_we", 32'(wrEnable), 32'h0);
        applyStimulus(2'b11, 4'h7, 8'h77, 4'h8, 8'h88, 1'b0);
        checkOutput("release_ready", 32'(reqReady), 32'h2);
        stepCycle();
        checkOutput("release_gidx", 32'(grantIdx), 32'h1);
        checkOutput("release_addr", 32'(wrAddr), 32'h8);
        checkOutput("release_data", 32'(wrData), 32'h88);
        applyStimulus(2'b01, 4'h7, 8'h77, 4'h8, 8'h88, 1'b0);
        checkOutput("release2_ready", 32'(reqReady), 32'h1);
        stepCycle();
        checkOutput("release2_gidx", 32'(grantIdx), 32'h0);
        checkOutput("release2_data", 32'(wrData), 32'h77);
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
        stepCycle();

        // Reset mid-stream: pointer is at 1, grant requester 1 then assert reset
        applyStimulus(2'b10, 4'h0, 8'h00, 4'h9, 8'h99, 1'b0);
        checkOutput("midrst_ready", 32'(reqReady), 32'h2);
        stepCycle();
        reset = 1'b1;
        applyStimulus(2'b01, 4'h0, 8'h00, 4'h9, 8'h99, 1'b0);
        checkOutput("midrst_ready_rst", 32'(reqReady), 32'h0);
        checkOutput("midrst_we_t1", 32'(wrEnable), 32'h1);
        checkOutput("midrst_data_t1", 32'(wrData), 32'h99);
        stepCycle();
        checkOutput("midrst_we_t2", 32'(wrEnable), 32'h0);
        checkOutput("midrst_addr_t2", 32'(wrAddr), 32'h0);
        checkOutput("midrst_ready_t2", 32'(reqReady), 32'h0);

        // Release into a same-address collision; requester 0 has priority again
        reset = 1'b0;
        applyStimulus(2'b11, 4'h5, 8'h10, 4'h5, 8'h20, 1'b0);
        checkOutput("coll_ready0", 32'(reqReady), 32'h1);
        stepCycle();
        checkOutput("coll_data0", 32'(wrData), 32'h10);
        checkOutput("coll_addr0", 32'(wrAddr), 32'h5);
        applyStimulus(2'b10, 4'h5, 8'h10, 4'h5, 8'h20, 1'b0);
        checkOutput("coll_ready1", 32'(reqReady), 32'h2);
        stepCycle();
        checkOutput("coll_data1", 32'(wrData), 32'h20);
        checkOutput("coll_we1", 32'(wrEnable), 32'h1);
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
        stepCycle();
        checkOutput("coll_rf5", 32'(regFile[5]), 32'h20);
        checkOutput("coll_we_off", 32'(wrEnable), 32'h0);

`ifdef REGFILE_WR_ARB_STATS_EN
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("stats_rst_conf", 32'(conflictCount), 32'h0);
        checkOutput("stats_rst_stall", 32'(stallCount), 32'h0);
        applyStimulus(2'b11, 4'h1, 8'h11, 4'h2, 8'h22, 1'b0);
        repeat (5) stepCycle();
        applyStimulus(2'b01, 4'h1, 8'h11, 4'h2, 8'h22, 1'b1);
        repeat (2) stepCycle();
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
        stepCycle();
        checkOutput("stats_conf", 32'(conflictCount), 32'd5);
        checkOutput("stats_stall", 32'(stallCount), 32'd2);

        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        applyStimulus(2'b11, 4'h1, 8'h11, 4'h2, 8'h22, 1'b1);
        repeat (65540) stepCycle();
        checkOutput("stats_conf_sat", 32'(conflictCount), 32'hFFFF);
        checkOutput("stats_stall_sat", 32'(stallCount), 32'hFFFF);
        applyStimulus(2'b00, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (wr_addr / wr_enable / wr_data) between NUM_REQ writeback sources, e.g. ALU result and memory-load return.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the write port from registers, giving one cycle of latency.
- Sits between the execute/memory writeback stages and the register file.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_BITS, REGISTER_ADDRESS_BITS, register address width.
- DATA_BITS, REGISTER_DATA_BITS, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_BITS  flattened target addresses; requester i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- req_data  input  NUM_REQ*DATA_BITS  flattened write data, same packing as req_addr.
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- wr_stall  input  1  when high, no grant is issued this cycle.
- wr_addr  output  ADDR_BITS  register file write address.
- wr_enable  output  1  register file write strobe.
- wr_data  output  DATA_BITS  register file write data.
- grant_idx  output  $clog2(NUM_REQ)  index of the requester whose write is on the port this cycle; valid only while wr_enable=1.

Behaviour:
- Reset values: wr_enable=0, wr_addr=0, wr_data=0, grant_idx=0, rr_ptr=0.
- req_ready is forced to 0 while reset=1.
- req_ready is combinational from req_valid, rr_ptr, wr_stall and reset. At most one bit is set.
- It is never asserted for a requester whose req_valid is 0.
- Round-robin rule: search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ. The first index with req_valid=1 is granted, provided wr_stall=0.
- On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ.
- With no grant (no valid requester, or wr_stall=1), rr_ptr holds its value.
- Output register, next edge after a grant to g:
  - wr_enable <= 1
  - wr_addr <= req_addr[g]
  - wr_data <= req_data[g]
  - grant_idx <= g
- With no grant: wr_enable <= 0; wr_addr, wr_data and grant_idx hold their values.
- Latency: the transfer cycle is T; the register file write strobe is in cycle T+1.
- Back-to-back grants are allowed, giving throughput of one write per cycle.
- Requester obligation: once req_valid is asserted, hold req_valid, req_addr and req_data stable until the transfer. The arbiter does not check this.
- Requester may deassert after the transfer or present a new request in the next cycle.
- Simultaneous requests to the same address are serialized in round-robin order; the later write wins in the register file. No merging or suppression is performed.
- wr_stall=1 blocks new grants only. A write already registered in the output stage still completes in the next cycle.
- Reset asserted mid-stream: any pending output write is discarded (wr_enable=0 next cycle), rr_ptr returns to 0, and outstanding requests are not granted until reset deasserts.
- Fairness: with all requesters continuously valid, each requester is granted exactly once every NUM_REQ cycles.

Optional Feature:
- Macro: REGFILE_WR_ARB_STATS_EN.
- Defined:
  - Adds output conflict_count (16 bits, reset 0). It increments on every cycle where two or more req_valid bits are high and reset=0, and saturates at 16'hFFFF.
  - Adds output stall_count (16 bits, reset 0). It increments on every cycle where wr_stall=1 and at least one req_valid is high, and also saturates.
- Undefined: neither port nor counter exists. Arbitration behaviour is identical in both builds.

Test Plan (NUM_REQ=2, ADDR_BITS=4, DATA_BITS=8):
- Single request: req_valid=2'b01, addr0=4'h3, data0=8'hA5 in cycle T
  -> req_ready=2'b01 in T
  -> in T+1: wr_enable=1, wr_addr=3, wr_data=A5, grant_idx=0
  -> in T+2: wr_enable=0.
- Continuous contention: both valid for 4 cycles from reset (addr0=1/data0=11, addr1=2/data1=22)
  -> grants alternate 0,1,0,1
  -> write port shows (1,11),(2,22),(1,11),(2,22) in consecutive cycles.
- Stall: both valid, wr_stall=1 for 3 cycles
  -> req_ready=0 and wr_enable=0 throughout; rr_ptr unchanged
  -> on release, the requester at rr_ptr is granted first.
- Same-address collision: addr0=addr1=4'h5, data0=8'h10, data1=8'h20, rr_ptr=0
  -> writes 10 then 20 in consecutive cycles; the register file ends holding 20.
- Reset mid-stream: grant in cycle T, reset=1 in T+1
  -> wr_enable=0 from T+2, req_ready=0 while reset is high
  -> after release, requester 0 has priority.
- With REGFILE_WR_ARB_STATS_EN: 5 cycles of both valid plus 2 stalled cycles with one valid
  -> conflict_count=5, stall_count=2.
  - Saturation: force 65540 conflict cycles -> conflict_count holds at FFFF.
